// File: rtl/line_fifo_sequencer.sv
// line_fifo_sequencer: owns the shared line FIFO port and walks each board
// through RECEIVE -> SOLVE -> TRANSMIT. It muxes the parser/solver write
// ports, gates solver reads, drains leftovers, tracks occupancy and flags
// overflow, underflow and solver stalls on the status LEDs.
module line_fifo_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 1024,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               parse_write,
    input  logic [DATA_WIDTH-1:0]              parse_line,
    input  logic                               parsed,
    input  logic                               solve_write,
    input  logic [DATA_WIDTH-1:0]              solve_line,
    input  logic                               solve_next,
    input  logic                               solved,
    input  logic                               assembled,
    input  logic                               fifo_full,
    input  logic                               fifo_empty,
    output logic                               fifo_wr_en,
    output logic [DATA_WIDTH-1:0]              fifo_din,
    output logic                               fifo_rd_en,
    output logic                               solver_start,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy,
    output logic [15:0]                        lines_received,
    output logic [1:0]                         err_code,
    output logic [2:0]                         stat
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RECEIVE  = 2'd0,
        S_SOLVE    = 2'd1,
        S_TRANSMIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic            asm_seen;   // assembler finished while the drain was still running

    logic wreq;
    logic rreq;
    logic err_ovf;
    logic err_unf;
    logic err_to;

    // FIFO port muxing and error detection, zero latency from state and inputs
    always_comb begin
        wreq     = 1'b0;
        rreq     = 1'b0;
        fifo_din = solve_line;
        case (state)
            S_RECEIVE: begin
                wreq     = parse_write;
                fifo_din = parse_line;
            end
            S_SOLVE: begin
                wreq = solve_write;
                rreq = solve_next;
            end
            S_TRANSMIT: rreq = ~fifo_empty;
            default: ;
        endcase
        fifo_wr_en = wreq & ~fifo_full;
        fifo_rd_en = rreq & ~fifo_empty;
        err_ovf    = wreq & fifo_full;
        err_unf    = (state == S_SOLVE) & solve_next & fifo_empty;
        // A stall is only declared on a cycle that is itself idle
        err_to     = (state == S_SOLVE) & ~fifo_wr_en & ~fifo_rd_en &
                     (watchdog == WD_LAST);
    end

    // Board flow FSM with occupancy, line count, watchdog and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_RECEIVE;
            stat           <= 3'b001;
            occupancy      <= '0;
            lines_received <= 16'd0;
            err_code       <= 2'd0;
            solver_start   <= 1'b0;
            watchdog       <= '0;
            asm_seen       <= 1'b0;
        end else begin
            solver_start <= 1'b0;

            if (fifo_wr_en && !fifo_rd_en)
                occupancy <= occupancy + OCC_ONE;
            else if (fifo_rd_en && !fifo_wr_en)
                occupancy <= occupancy - OCC_ONE;

            case (state)
                S_RECEIVE: begin
                    if (fifo_wr_en && lines_received != 16'hFFFF)
                        lines_received <= lines_received + 16'd1;
                    if (err_ovf) begin
                        state    <= S_ERROR;
                        stat     <= 3'b111;
                        err_code <= 2'd1;
                    end else if (parsed) begin
                        state        <= S_SOLVE;
                        stat         <= 3'b010;
                        solver_start <= 1'b1;
                        watchdog     <= '0;
                    end
                end

                S_SOLVE: begin
                    if (fifo_wr_en || fifo_rd_en)
                        watchdog <= '0;
                    else
                        watchdog <= watchdog + WD_ONE;
                    // solved outranks a stall but not a bad FIFO access
                    if (err_ovf) begin
                        state    <= S_ERROR;
                        stat     <= 3'b111;
                        err_code <= 2'd1;
                    end else if (err_unf) begin
                        state    <= S_ERROR;
                        stat     <= 3'b111;
                        err_code <= 2'd2;
                    end else if (solved) begin
                        state    <= S_TRANSMIT;
                        stat     <= 3'b100;
                        asm_seen <= 1'b0;
                    end else if (err_to) begin
                        state    <= S_ERROR;
                        stat     <= 3'b111;
                        err_code <= 2'd3;
                    end
                end

                S_TRANSMIT: begin
                    if (assembled)
                        asm_seen <= 1'b1;
                    if ((assembled || asm_seen) && fifo_empty && !fifo_rd_en) begin
                        state          <= S_RECEIVE;
                        stat           <= 3'b001;
                        lines_received <= 16'd0;
                        asm_seen       <= 1'b0;
                    end
                end

                default: ;  // ERROR holds until rst
            endcase
        end
    end

endmodule

// File: tb/tb_line_fifo_sequencer.sv
// Bench for line_fifo_sequencer: a vector table, directed board flows and a
// randomized run, all checked against a cycle-level board-flow model.
module tb_line_fifo_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int TMO   = 100;
    localparam int MR = 0, MS = 1, MT = 2, ME = 3;

    logic          clk = 1'b0;
    logic          rst, parse_write, parsed, solve_write, solve_next;
    logic          solved, assembled, fifo_full, fifo_empty;
    logic [DW-1:0] parse_line, solve_line;
    logic          fifo_wr_en, fifo_rd_en, solver_start;
    logic [DW-1:0] fifo_din;
    logic [5:0]    occupancy;
    logic [15:0]   lines_received;
    logic [1:0]    err_code;
    logic [2:0]    stat;

    logic frc_full, frc_empty;
    logic s_wr, s_rd;
    logic [DW-1:0] s_din;

    int nchk = 0;
    int nerr = 0;

    // Board-flow model
    int m_st, m_cnt, m_lines, m_err, m_idle;
    bit m_asm, m_start;

    typedef struct packed {
        logic pw; logic [15:0] pl; logic ps;
        logic sw; logic [15:0] sl; logic sn;
        logic sv; logic as_; logic ff;
        logic e_wr; logic e_rd; logic [15:0] e_din; logic [2:0] e_stat; logic [5:0] e_occ;
    } vec_t;
    vec_t vt [0:8];

    line_fifo_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .parse_write(parse_write), .parse_line(parse_line), .parsed(parsed),
        .solve_write(solve_write), .solve_line(solve_line), .solve_next(solve_next),
        .solved(solved), .assembled(assembled),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
        .solver_start(solver_start), .occupancy(occupancy),
        .lines_received(lines_received), .err_code(err_code), .stat(stat)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: run did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] stat_of(input int s);
        case (s)
            MR:      return 3'b001;
            MS:      return 3'b010;
            MT:      return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    task automatic model_reset();
        m_st = MR; m_cnt = 0; m_lines = 0; m_err = 0; m_idle = 0;
        m_asm = 0; m_start = 0;
    endtask

    task automatic clear_inputs();
        rst = 0; parse_write = 0; parse_line = '0; parsed = 0;
        solve_write = 0; solve_line = '0; solve_next = 0;
        solved = 0; assembled = 0; frc_full = 0; frc_empty = 0;
    endtask

    // Advance the model by one clock using the values the DUT sampled
    task automatic model_step(input bit wr, input bit rd);
        bit start_n;
        start_n = 0;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_st)
            MR: begin
                if (parse_write && fifo_full) begin
                    m_st = ME; m_err = 1;
                end else begin
                    if (wr) m_lines = (m_lines == 65535) ? 65535 : m_lines + 1;
                    if (parsed) begin
                        m_st = MS; start_n = 1; m_idle = 0;
                    end
                end
            end
            MS: begin
                if (solve_write && fifo_full) begin
                    m_st = ME; m_err = 1;
                end else if (solve_next && fifo_empty) begin
                    m_st = ME; m_err = 2;
                end else if (solved) begin
                    m_st = MT; m_asm = 0;
                end else if (!wr && !rd) begin
                    m_idle++;
                    if (m_idle >= TMO) begin
                        m_st = ME; m_err = 3;
                    end
                end else begin
                    m_idle = 0;
                end
            end
            MT: begin
                if (assembled) m_asm = 1;
                if (m_asm && fifo_empty && !rd) begin
                    m_st = MR; m_lines = 0; m_asm = 0;
                end
            end
            default: ;
        endcase
        m_cnt = m_cnt + int'(wr) - int'(rd);
        m_start = start_n;
    endtask

    // One cycle: inputs already set after a negedge; flags come from the
    // model FIFO count, comb outputs checked at #1, registered at next negedge
    task automatic tick();
        bit e_wr, e_rd;
        logic [DW-1:0] e_din;
        fifo_empty = (m_cnt == 0) || frc_empty;
        fifo_full  = (m_cnt >= DEPTH) || frc_full;
        #1;
        e_wr  = ((m_st == MR && parse_write) || (m_st == MS && solve_write)) && !fifo_full;
        e_rd  = ((m_st == MS && solve_next) || m_st == MT) && !fifo_empty;
        e_din = (m_st == MR) ? parse_line : solve_line;
        s_wr = fifo_wr_en; s_rd = fifo_rd_en; s_din = fifo_din;
        chk("m_wr_en", fifo_wr_en, e_wr);
        chk("m_rd_en", fifo_rd_en, e_rd);
        chk("m_din", fifo_din, e_din);
        @(posedge clk);
        model_step(e_wr, e_rd);
        @(negedge clk);
        chk("m_occupancy", occupancy, m_cnt);
        chk("m_lines", lines_received, m_lines);
        chk("m_err", err_code, m_err);
        chk("m_stat", stat, stat_of(m_st));
        chk("m_start", solver_start, m_start);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        int wrn, rdn, k;
        clear_inputs();
        fifo_full = 0; fifo_empty = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_stat", stat, 3'b001);
        chk("rst_occ", occupancy, 0);
        chk("rst_lines", lines_received, 0);
        chk("rst_err", err_code, 0);
        chk("rst_start", solver_start, 0);
        rst = 0;

        // Vector table: pw pl ps sw sl sn sv as ff | wr rd din stat occ
        vt[0] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 3'b001, 6'd1};
        vt[1] = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBBBB, 3'b010, 6'd2};
        vt[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 3'b010, 6'd1};
        vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 3'b010, 6'd1};
        vt[4] = '{1'b1, 16'h7777, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4321, 3'b010, 6'd1};
        vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b100, 6'd1};
        vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b100, 6'd0};
        vt[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b001, 6'd0};
        vt[8] = '{1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999, 3'b111, 6'd0};
        for (int i = 0; i < 9; i++) begin
            parse_write = vt[i].pw; parse_line = vt[i].pl; parsed = vt[i].ps;
            solve_write = vt[i].sw; solve_line = vt[i].sl; solve_next = vt[i].sn;
            solved = vt[i].sv; assembled = vt[i].as_; frc_full = vt[i].ff;
            tick();
            chk($sformatf("vec%0d_wr", i), s_wr, vt[i].e_wr);
            chk($sformatf("vec%0d_rd", i), s_rd, vt[i].e_rd);
            chk($sformatf("vec%0d_din", i), s_din, vt[i].e_din);
            chk($sformatf("vec%0d_stat", i), stat, vt[i].e_stat);
            chk($sformatf("vec%0d_occ", i), occupancy, vt[i].e_occ);
        end
        chk("vec_err_ovf", err_code, 2'd1);

        // 22 parser lines then parsed
        do_reset();
        wrn = 0;
        for (int i = 1; i <= 22; i++) begin
            clear_inputs(); parse_write = 1; parse_line = 16'(i);
            tick();
            wrn += int'(s_wr);
        end
        clear_inputs(); parsed = 1;
        tick();
        chk("rx_writes", wrn, 22);
        chk("rx_occ", occupancy, 22);
        chk("rx_lines", lines_received, 22);
        chk("rx_start_hi", solver_start, 1);
        chk("rx_stat_solve", stat, 3'b010);
        clear_inputs();
        tick();
        chk("rx_start_lo", solver_start, 0);

        // Solver traffic with parse_write held high
        clear_inputs(); parse_write = 1; solve_next = 1; solve_write = 1; solve_line = 16'hC0DE;
        tick();
        chk("sv_both_din", s_din, 16'hC0DE);
        chk("sv_both_en", {s_wr, s_rd}, 2'b11);
        solve_write = 0;
        repeat (4) tick();
        solve_next = 0; solve_write = 1; solve_line = 16'h0BAD;
        repeat (2) tick();
        chk("sv_occ20", occupancy, 20);

        // Drain to 4, solved, assembled early, wait for empty
        clear_inputs(); solve_next = 1;
        repeat (16) tick();
        clear_inputs(); solved = 1;
        tick();
        chk("tx_occ4", occupancy, 4);
        clear_inputs(); assembled = 1;
        tick();
        assembled = 0;
        rdn = int'(s_rd);
        k = 1;
        while (stat != 3'b001 && k < 20) begin
            tick();
            rdn += int'(s_rd);
            k++;
        end
        chk("tx_reads", rdn, 4);
        chk("tx_ticks", k, 5);
        chk("tx_occ0", occupancy, 0);
        chk("tx_lines0", lines_received, 0);
        chk("tx_stat_rx", stat, 3'b001);

        // Overflow, then reset recovery
        clear_inputs(); parse_write = 1; frc_full = 1;
        tick();
        chk("ovf_wr", s_wr, 0);
        chk("ovf_err", err_code, 1);
        chk("ovf_stat", stat, 3'b111);
        do_reset();
        chk("ovf_rst_err", err_code, 0);
        chk("ovf_rst_stat", stat, 3'b001);

        // Timeout after 100 idle SOLVE cycles
        clear_inputs(); parsed = 1;
        tick();
        clear_inputs();
        repeat (TMO - 1) tick();
        chk("to_err_early", err_code, 0);
        tick();
        chk("to_err", err_code, 3);
        chk("to_stat", stat, 3'b111);
        do_reset();
        clear_inputs(); parsed = 1;
        tick();
        clear_inputs();
        repeat (TMO - 1) tick();
        solved = 1;
        tick();
        chk("to_solved_stat", stat, 3'b100);
        chk("to_solved_err", err_code, 0);
        clear_inputs(); assembled = 1;
        tick();
        chk("to_back_rx", stat, 3'b001);

        // Reset mid-SOLVE with 7 words
        clear_inputs(); parse_write = 1;
        repeat (7) tick();
        clear_inputs(); parsed = 1;
        tick();
        chk("mid_occ7", occupancy, 7);
        do_reset();
        chk("mid_occ0", occupancy, 0);
        chk("mid_stat", stat, 3'b001);
        clear_inputs();
        tick();
        chk("mid_en", {s_wr, s_rd}, 2'b00);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            clear_inputs();
            rst         = ($urandom_range(0, 199) == 0) || (m_st == ME && $urandom_range(0, 9) == 0);
            parse_write = 1'($urandom_range(0, 1));
            parse_line  = 16'($urandom);
            parsed      = ($urandom_range(0, 15) == 0);
            solve_write = ($urandom_range(0, 2) == 0);
            solve_line  = 16'($urandom);
            solve_next  = ($urandom_range(0, 2) == 0);
            solved      = ($urandom_range(0, 19) == 0);
            assembled   = ($urandom_range(0, 7) == 0);
            frc_full    = ($urandom_range(0, 39) == 0);
            frc_empty   = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
